bin2bcd_seq: RTL and testbench
==============================

Name: bin2bcd_seq

Overview:
- Parametrised sequential binary-to-decimal converter; successor to the team's single-digit combinational BCD code converter.
- Converts a BIN_W-bit unsigned value into DIGITS packed decimal digits by shift-and-add-3 (double dabble), one bit per clock.
- Feeds the 7-segment display path and any downstream decimal-code logic. Uses a start/ready/done handshake.

Parameters:
- BIN_W, 8, width of the binary input; must be 1 or greater.
- DIGITS, 3, number of 4-bit decimal output digits; must be 1 or greater. An undersized DIGITS is legal and is reported through overflow.

Ports:
- clk  in  1  system clock; all state changes on its rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  request to convert; sampled only while ready=1.
- bin_in  in  BIN_W  unsigned operand; latched on the accepted start.
- ready  out  1  high in IDLE; decoded from state, not registered.
- done  out  1  registered one-cycle pulse when the result is valid.
- bcd_out  out  4*DIGITS  digit 0 in bits [3:0]; registered; holds its value until the next done.
- overflow  out  1  registered; valid alongside done; holds until the next done.

Behaviour:
- Reset, asynchronous on rst_n low:
  - state goes to IDLE.
  - bcd_out=0, done=0, overflow=0, internal shift register and counter cleared.
  - ready=1 as soon as rst_n is released.
  - Reset asserted mid-conversion aborts it; no done is produced.
- States: IDLE, SHIFT, DONE.
- IDLE:
  - start=1 on an edge loads bin_in into the binary shifter.
  - Clears the digit accumulator, the sticky overflow bit and the counter, then moves to SHIFT.
- SHIFT: each cycle has two steps.
  - First, every 4-bit digit in the accumulator that is 5 or greater gets 3 added, all digits in parallel.
  - Then the combined {accumulator, shifter} shifts left by one bit, with the shifter MSB entering digit 0 bit 0.
  - A 1 shifted out of the top digit's MSB sets sticky overflow.
  - The counter increments. When it reaches BIN_W-1 the FSM moves to DONE after that shift.
- DONE, one cycle:
  - The accumulator, passed through the optional encoder, is registered into bcd_out; overflow is registered; done=1.
  - The FSM returns to IDLE on the next edge.
- Latency: start accepted at edge k gives done=1 in the cycle after edge k+BIN_W+1. Throughput is one conversion per BIN_W+2 cycles.
- start while ready=0 is ignored; it is not queued.
- start held high keeps triggering back-to-back conversions, each taking a new bin_in sample on re-entry to IDLE.
- On overflow, bcd_out holds the low DIGITS digits of the true result (modulo 10^DIGITS).

Optional Feature:
- Macro: BIN2BCD_CODE2421_EN.
- Defined: each digit is mapped to 2421 code before being registered into bcd_out.
  - 0-4 map unchanged.
  - 5 maps to 1011, 6 to 1100, 7 to 1101, 8 to 1110, 9 to 1111.
- Undefined: bcd_out is plain 8421 BCD and the encoder is not instantiated.
- Latency and handshake are identical in both builds.

Decomposition:
- Package bcd_pkg holds:
  - the state encoding localparams (IDLE=2'd0, SHIFT=2'd1, DONE=2'd2);
  - ADJ_THRESH=4'd5 and ADJ_ADD=4'd3;
  - the DIGIT_W=4 constant.
- One sub-module, bcd_digit_2421: a 4-bit combinational digit encoder, instantiated DIGITS times in a generate loop under the macro.
- The add-3 adjust stays inline as a function.

Test Plan:
- Defaults, bin_in=8'd255, start pulse: done rises 10 cycles after start is sampled; bcd_out=12'h255, overflow=0.
- bin_in=0, then bin_in=8'd100: results 12'h000 and 12'h100. ready is low for exactly BIN_W+1 cycles each time.
- DIGITS=2, bin_in=8'd100: bcd_out=8'h00, overflow=1. A following conversion of 8'd42 gives 8'h42 and overflow=0.
- start re-pulsed with bin_in=8'd7 during SHIFT of a conversion of 8'd93: that start is ignored; the result is 12'h093 with a single done pulse.
- rst_n pulsed low in the 4th SHIFT cycle: outputs immediately return to 0 and ready=1; no done follows; the next conversion of 8'd58 gives 12'h058.
- With BIN2BCD_CODE2421_EN defined, bin_in=8'd59: bcd_out=12'b0000_1011_1111. Sweep all 0..255 against a reference model.

Source files
------------

// File: rtl/bcd_pkg.sv
// ----------------------------------------------------------------------------
// bcd_pkg
// Shared constants for the sequential binary-to-BCD converter:
//   - state_t    : FSM state encoding (IDLE=0, SHIFT=1, DONE=2)
//   - DIGIT_W    : width of one packed decimal digit
//   - ADJ_THRESH : digit value at or above which the add-3 correction applies
//   - ADJ_ADD    : the correction added to such a digit before each shift
// ----------------------------------------------------------------------------
package bcd_pkg;

    localparam int DIGIT_W = 4;

    localparam logic [DIGIT_W-1:0] ADJ_THRESH = 4'd5;
    localparam logic [DIGIT_W-1:0] ADJ_ADD    = 4'd3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

endpackage : bcd_pkg

// File: rtl/bcd_digit_2421.sv
// ----------------------------------------------------------------------------
// bcd_digit_2421
// Combinational single-digit 8421 BCD to 2421 code encoder.
//   bcd  : input digit, 0..9 in 8421 BCD
//   code : the same digit in 2421 code (0-4 unchanged, 5-9 -> 1011..1111)
// Non-decimal inputs (10..15) never occur in the converter; they pass through.
// ----------------------------------------------------------------------------
module bcd_digit_2421
    import bcd_pkg::*;
(
    input  logic [DIGIT_W-1:0] bcd,
    output logic [DIGIT_W-1:0] code
);

    // NOTE: assigning a default before the case means every path writes
    // 'code', so no latch is inferred even if a case arm is missed.
    always_comb begin
        code = bcd;
        case (bcd)
            4'd5:    code = 4'b1011;
            4'd6:    code = 4'b1100;
            4'd7:    code = 4'b1101;
            4'd8:    code = 4'b1110;
            4'd9:    code = 4'b1111;
            default: code = bcd;
        endcase
    end

endmodule : bcd_digit_2421

// File: rtl/bin2bcd_seq.sv
// ----------------------------------------------------------------------------
// bin2bcd_seq
// Sequential binary-to-decimal converter using shift-and-add-3 (double
// dabble), one input bit per clock.
//
// Parameters:
//   BIN_W  : width of the unsigned binary operand (>= 1)
//   DIGITS : number of 4-bit decimal output digits (>= 1)
//
// Ports:
//   clk      : system clock, rising edge
//   rst_n    : asynchronous active-low reset
//   start    : conversion request, sampled only while ready=1
//   bin_in   : operand, latched on the accepted start
//   ready    : high while idle (decoded from state)
//   done     : registered one-cycle pulse when bcd_out/overflow are updated
//   bcd_out  : packed digits, digit 0 in bits [3:0]; held until next done
//   overflow : result did not fit in DIGITS digits; held until next done
//
// Build option:
//   BIN2BCD_CODE2421_EN : when defined, each digit is re-encoded to 2421 code
//                         before being registered into bcd_out.
//
// Timing: start accepted at edge k -> done high after edge k+BIN_W+1;
// one conversion every BIN_W+2 cycles with start held high.
// ----------------------------------------------------------------------------
module bin2bcd_seq
    import bcd_pkg::*;
#(
    parameter int BIN_W  = 8,
    parameter int DIGITS = 3
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      start,
    input  logic [BIN_W-1:0]          bin_in,
    output logic                      ready,
    output logic                      done,
    output logic [DIGIT_W*DIGITS-1:0] bcd_out,
    output logic                      overflow
);

    localparam int AW    = DIGIT_W * DIGITS;
    localparam int CNT_W = (BIN_W > 1) ? $clog2(BIN_W) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BIN_W - 1);

    state_t             state, state_nxt;
    logic [BIN_W-1:0]   bin_q;
    logic [AW-1:0]      acc_q;
    logic               ovf_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [AW-1:0]      acc_adj;
    logic [AW-1:0]      enc_acc;

    // Add 3 to every digit that is 5 or more, all digits in parallel, so the
    // following left shift carries correctly into the next decimal digit.
    function automatic logic [AW-1:0] add3_adjust(input logic [AW-1:0] acc);
        logic [AW-1:0]      res;
        logic [DIGIT_W-1:0] dig;
        res = acc;
        for (int i = 0; i < DIGITS; i++) begin
            dig = acc[i*DIGIT_W +: DIGIT_W];
            if (dig >= ADJ_THRESH) begin
                res[i*DIGIT_W +: DIGIT_W] = dig + ADJ_ADD;
            end
        end
        return res;
    endfunction

    assign acc_adj = add3_adjust(acc_q);

    // ------------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of block evaluation order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = SHIFT;
            SHIFT:   if (cnt_q == CNT_LAST) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign ready = (state == IDLE);

    // ------------------------------------------------------------------------
    // Optional output encoding
    // ------------------------------------------------------------------------
`ifdef BIN2BCD_CODE2421_EN
    for (genvar g = 0; g < DIGITS; g++) begin : g_enc
        bcd_digit_2421 u_enc (
            .bcd  (acc_q[g*DIGIT_W +: DIGIT_W]),
            .code (enc_acc[g*DIGIT_W +: DIGIT_W])
        );
    end
`else
    assign enc_acc = acc_q;
`endif

    // ------------------------------------------------------------------------
    // Datapath
    // ------------------------------------------------------------------------
    // NOTE: the shifter, accumulator and counter are plain flops (not a
    // memory), so they are cleared by reset along with the outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bin_q    <= '0;
            acc_q    <= '0;
            ovf_q    <= 1'b0;
            cnt_q    <= '0;
            bcd_out  <= '0;
            overflow <= 1'b0;
            done     <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        bin_q <= bin_in;
                        acc_q <= '0;
                        ovf_q <= 1'b0;
                        cnt_q <= '0;
                    end
                end
                SHIFT: begin
                    // {acc, bin} shifts left as one register; the bit leaving
                    // the top digit is lost and marks the result as overflowed.
                    acc_q <= {acc_adj[AW-2:0], bin_q[BIN_W-1]};
                    bin_q <= bin_q << 1;
                    if (acc_adj[AW-1]) ovf_q <= 1'b1;
                    cnt_q <= cnt_q + 1'b1;
                end
                DONE: begin
                    bcd_out  <= enc_acc;
                    overflow <= ovf_q;
                    done     <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule : bin2bcd_seq

// File: tb/tb_bin2bcd_seq.sv
// ----------------------------------------------------------------------------
// tb_bin2bcd_seq
// Directed bench for bin2bcd_seq: a 3-digit instance (dut) and a deliberately
// undersized 2-digit instance (dut2) share clock and reset. Expected results
// come from an arithmetic decimal model (divide/modulo by 10), are queued when
// start is driven and popped when done is observed. Outputs are sampled on the
// falling clock edge. When BIN2BCD_CODE2421_EN is defined the model applies
// the 2421 mapping as well.
// ----------------------------------------------------------------------------
module tb_bin2bcd_seq;

    localparam int BIN_W = 8;

    typedef struct {
        logic [11:0] bcd;
        logic        ovf;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;

    logic        start = 1'b0;
    logic [7:0]  bin_in = '0;
    logic        ready, done, overflow;
    logic [11:0] bcd_out;

    logic        start2 = 1'b0;
    logic [7:0]  bin_in2 = '0;
    logic        ready2, done2, overflow2;
    logic [7:0]  bcd_out2;

    int tests = 0;
    int fails = 0;
    exp_t sb[$];

    always #5 clk = ~clk;

    bin2bcd_seq #(.BIN_W(BIN_W), .DIGITS(3)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .bin_in   (bin_in),
        .ready    (ready),
        .done     (done),
        .bcd_out  (bcd_out),
        .overflow (overflow)
    );

    bin2bcd_seq #(.BIN_W(BIN_W), .DIGITS(2)) dut2 (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start2),
        .bin_in   (bin_in2),
        .ready    (ready2),
        .done     (done2),
        .bcd_out  (bcd_out2),
        .overflow (overflow2)
    );

    // ---------------- reference model ----------------
    function automatic logic [3:0] enc_digit(input int d);
`ifdef BIN2BCD_CODE2421_EN
        case (d)
            5:       return 4'b1011;
            6:       return 4'b1100;
            7:       return 4'b1101;
            8:       return 4'b1110;
            9:       return 4'b1111;
            default: return 4'(d);
        endcase
`else
        return 4'(d);
`endif
    endfunction

    function automatic exp_t model(input logic [7:0] v, input int digits);
        exp_t e;
        int   val;
        val   = int'(v);
        e.bcd = '0;
        for (int i = 0; i < digits; i++) begin
            e.bcd[i*4 +: 4] = enc_digit(val % 10);
            val = val / 10;
        end
        e.ovf = (val != 0);
        return e;
    endfunction

    // ---------------- helpers ----------------
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input int sel, input logic s, input logic [7:0] v);
        if (sel == 0) begin
            start  = s;
            bin_in = v;
        end else begin
            start2  = s;
            bin_in2 = v;
        end
    endtask

    function automatic logic get_ready(input int sel);
        return (sel == 0) ? ready : ready2;
    endfunction

    function automatic logic get_done(input int sel);
        return (sel == 0) ? done : done2;
    endfunction

    function automatic logic [11:0] get_bcd(input int sel);
        return (sel == 0) ? bcd_out : {4'h0, bcd_out2};
    endfunction

    function automatic logic get_ovf(input int sel);
        return (sel == 0) ? overflow : overflow2;
    endfunction

    // Runs one conversion from a falling edge. Optionally re-pulses start
    // (with operand 7) at falling edge 'repulse_at' while the DUT is busy.
    task automatic convert(input int sel, input logic [7:0] v, input int repulse_at);
        exp_t e;
        int   cyc;
        int   rdy_low;
        bit   seen;
        sb.push_back(model(v, (sel == 0) ? 3 : 2));
        drive(sel, 1'b1, v);
        cyc     = 0;
        rdy_low = 0;
        seen    = 1'b0;
        while (!seen && cyc < 40) begin
            @(negedge clk);
            cyc++;
            if (cyc == 1) drive(sel, 1'b0, v);
            if (repulse_at != 0 && cyc == repulse_at)     drive(sel, 1'b1, 8'd7);
            if (repulse_at != 0 && cyc == repulse_at + 1) drive(sel, 1'b0, 8'd7);
            if (!get_ready(sel)) rdy_low++;
            if (get_done(sel)) seen = 1'b1;
        end
        check($sformatf("done_seen v=%0d", v), 32'(seen), 32'd1);
        if (seen) begin
            check($sformatf("latency v=%0d", v), 32'(cyc), 32'(BIN_W + 2));
            check($sformatf("ready_low v=%0d", v), 32'(rdy_low), 32'(BIN_W + 1));
            check("sb_nonempty", 32'(sb.size() != 0), 32'd1);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                check($sformatf("bcd v=%0d", v), 32'(get_bcd(sel)), 32'(e.bcd));
                check($sformatf("ovf v=%0d", v), 32'(get_ovf(sel)), 32'(e.ovf));
            end
        end else begin
            sb.delete();
        end
    endtask

    // Watches for n falling edges and requires no done pulse.
    task automatic quiet(input int sel, input int n, input string tag);
        int extra;
        extra = 0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (get_done(sel)) extra++;
        end
        check(tag, 32'(extra), 32'd0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        #2;
        check("rst_ready",    32'(ready),    32'd1);
        check("rst_done",     32'(done),     32'd0);
        check("rst_bcd",      32'(bcd_out),  32'd0);
        check("rst_overflow", 32'(overflow), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_ready", 32'(ready), 32'd1);

        // Basic conversions, including the all-ones operand and zero.
        convert(0, 8'd255, 0);
        convert(0, 8'd0,   0);
        convert(0, 8'd100, 0);

        // Undersized instance: overflow then a fitting value, plus 99 edge.
        convert(1, 8'd100, 0);
        convert(1, 8'd42,  0);
        convert(1, 8'd99,  0);

        // Start re-pulsed during SHIFT is ignored: one result, one done.
        convert(0, 8'd93, 3);
        quiet(0, BIN_W + 4, "no_second_done");
        check("bcd_hold_093", 32'(bcd_out), 32'(model(8'd93, 3).bcd));

        // Reset in the 4th SHIFT cycle aborts the conversion.
        drive(0, 1'b1, 8'd200);
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk);
            if (c == 1) drive(0, 1'b0, 8'd200);
        end
        #1 rst_n = 1'b0;
        #1;
        check("abort_bcd",      32'(bcd_out),  32'd0);
        check("abort_overflow", 32'(overflow), 32'd0);
        check("abort_done",     32'(done),     32'd0);
        check("abort_ready",    32'(ready),    32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        quiet(0, BIN_W + 4, "no_done_after_abort");
        convert(0, 8'd58, 0);

        convert(0, 8'd59, 0);
`ifdef BIN2BCD_CODE2421_EN
        check("code2421_59", 32'(bcd_out), 32'(12'b0000_1011_1111));
`endif

        // Full operand sweep back to back.
        for (int v = 0; v < 256; v++) begin
            convert(0, 8'(v), 0);
        end

        check("sb_empty_end", 32'(sb.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule : tb_bin2bcd_seq
